// File: rtl/adpll_tx_ser.sv
// Byte-wide transmit serializer for the ADPLL data_mod input: small FIFO in,
// LSB-first bit stream out, each bit held BIT_CYCLES reference clocks.
module adpll_tx_ser #(
    parameter int BIT_CYCLES = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] adpll_mode,
    input  logic       channel_lock,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       data_mod,
    output logic       bit_stb,
    output logic       tx_busy,
    output logic       err_lock,
    output logic       err_underrun,
    input  logic       err_clr,
    output logic [1:0] dbg_state
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(BIT_CYCLES);
    localparam logic [DW-1:0] DIV_LAST = DW'(BIT_CYCLES - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t        state;
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    shreg;
    logic          cur_last;
    logic [2:0]    bit_idx;
    logic [DW-1:0] div;

    logic       fifo_empty;
    logic       fifo_full;
    logic       tx_ok;
    logic       abort;
    logic       byte_end;
    logic       flush;
    logic       push;
    logic       pop;
    logic [8:0] head;

    // Handshake: a byte is taken on any clock edge where tx_valid && tx_ready;
    // tx_ready is the only combinational output and never depends on tx_valid.
    assign tx_ready  = en && !fifo_full;
    assign dbg_state = state;

    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == FULL_CNT);
        head       = mem[rd_ptr];
        tx_ok      = channel_lock && (adpll_mode == 2'd3);
        abort      = (state == SEND) && !(tx_ok && en);
        byte_end   = (state == SEND) && !abort && (div == DIV_LAST) && (bit_idx == 3'd7);
        flush      = !en || abort;
        push       = tx_valid && tx_ready && !flush;
        pop        = !flush && !fifo_empty &&
                     (((state == ARM) && tx_ok) || (byte_end && !cur_last));
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {tx_last, tx_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            shreg        <= '0;
            cur_last     <= 1'b0;
            bit_idx      <= '0;
            div          <= '0;
            data_mod     <= 1'b0;
            bit_stb      <= 1'b0;
            tx_busy      <= 1'b0;
            err_lock     <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            bit_stb <= 1'b0;
            // Clear first so that a set later in this block wins.
            if (err_clr) begin
                err_lock     <= 1'b0;
                err_underrun <= 1'b0;
            end
            case (state)
                IDLE: begin
                    data_mod <= 1'b0;
                    if (en && !fifo_empty) begin
                        state   <= ARM;
                        tx_busy <= 1'b1;
                    end
                end
                ARM: begin
                    if (!en) begin
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                    end else if (pop) begin
                        state    <= SEND;
                        shreg    <= head[7:0];
                        cur_last <= head[8];
                        data_mod <= head[0];
                        bit_stb  <= 1'b1;
                        div      <= '0;
                        bit_idx  <= '0;
                    end
                end
                SEND: begin
                    if (abort) begin
                        state    <= IDLE;
                        tx_busy  <= 1'b0;
                        data_mod <= 1'b0;
                        div      <= '0;
                        bit_idx  <= '0;
                        if (en) err_lock <= 1'b1;
                    end else if (div != DIV_LAST) begin
                        div <= div + 1'b1;
                    end else if (bit_idx != 3'd7) begin
                        div      <= '0;
                        bit_idx  <= bit_idx + 3'd1;
                        data_mod <= shreg[1];
                        shreg    <= {1'b0, shreg[7:1]};
                        bit_stb  <= 1'b1;
                    end else if (pop) begin
                        // Next byte of the same frame starts with no gap.
                        shreg    <= head[7:0];
                        cur_last <= head[8];
                        data_mod <= head[0];
                        bit_stb  <= 1'b1;
                        div      <= '0;
                        bit_idx  <= '0;
                    end else begin
                        state    <= IDLE;
                        tx_busy  <= 1'b0;
                        data_mod <= 1'b0;
                        div      <= '0;
                        bit_idx  <= '0;
                        if (!cur_last) err_underrun <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adpll_tx_ser.sv
// Bench for adpll_tx_ser: random bytes are expanded into an LSB-first bit
// stream model and compared against what the serializer strobes out.
module tb_adpll_tx_ser;
    localparam int BC    = 32;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] adpll_mode = 2'd0;
    logic       channel_lock = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_last = 1'b0;
    logic       tx_valid = 1'b0;
    logic       err_clr = 1'b0;
    logic       tx_ready;
    logic       data_mod;
    logic       bit_stb;
    logic       tx_busy;
    logic       err_lock;
    logic       err_underrun;
    logic [1:0] dbg_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [0:0] exp_q[$];
    logic [0:0] got_q[$];
    int stb_t[$];
    int busy_cnt = 0;
    int fall_cnt = 0;
    int fall_t = 0;
    int glitch = 0;
    logic prev_dm = 1'b0;
    logic prev_busy = 1'b0;
    logic saw_full = 1'b0;

    adpll_tx_ser #(.BIT_CYCLES(BC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .adpll_mode(adpll_mode),
        .channel_lock(channel_lock), .tx_data(tx_data), .tx_last(tx_last),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .data_mod(data_mod),
        .bit_stb(bit_stb), .tx_busy(tx_busy), .err_lock(err_lock),
        .err_underrun(err_underrun), .err_clr(err_clr), .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycles=%0d limit=200000", cyc);
        $fatal(1, "bench stopped by watchdog");
    end

    // output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (bit_stb === 1'b1) begin
            got_q.push_back(data_mod);
            stb_t.push_back(cyc);
        end else if (tx_busy === 1'b1 && data_mod !== prev_dm) begin
            glitch++;
        end
        if (tx_busy === 1'b1) busy_cnt++;
        if (prev_busy === 1'b1 && tx_busy === 1'b0) begin
            fall_cnt++;
            fall_t = cyc;
        end
        prev_dm = data_mod;
        prev_busy = tx_busy;
    end

    // driver tasks and reference model
    task automatic clear_mon();
        got_q.delete();
        stb_t.delete();
        exp_q.delete();
        busy_cnt = 0;
        glitch = 0;
        saw_full = 1'b0;
    endtask

    task automatic add_byte_exp(input logic [7:0] b);
        for (int i = 0; i < 8; i++) exp_q.push_back(1'((b >> i) & 8'd1));
    endtask

    task automatic push_byte(input logic [7:0] d, input logic l);
        int guard;
        guard = 0;
        @(negedge clk);
        tx_data = d;
        tx_last = l;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && guard < 2000) begin
            saw_full = 1'b1;
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            total++; bad++;
            $display("FAIL push_timeout tx_ready=%0b required=1", tx_ready);
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic ok);
        int f0;
        int n;
        f0 = fall_cnt;
        n = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if (fall_cnt != f0) ok = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic wait_bits(input int nbits, output logic ok);
        int n;
        n = 0;
        while (got_q.size() < nbits && n < 2000) begin
            @(negedge clk);
            n++;
        end
        ok = (got_q.size() >= nbits);
    endtask

    // tests
    task automatic test_reset();
        rst = 1'b0; en = 1'b0;
        #2;
        total++;
        if ({data_mod, bit_stb, tx_busy, err_lock, err_underrun} !== 5'b0) begin
            bad++; $display("FAIL reset_outputs got=%b required=00000",
                            {data_mod, bit_stb, tx_busy, err_lock, err_underrun});
        end
        total++;
        if (tx_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_en0 got=%0b required=0", tx_ready); end
        en = 1'b1;
        #1;
        total++;
        if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_en1 got=%0b required=1", tx_ready); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (tx_busy !== 1'b0 || data_mod !== 1'b0) begin
            bad++; $display("FAIL reset_idle busy=%0b dm=%0b required=0,0", tx_busy, data_mod);
        end
    endtask

    task automatic test_single_frame();
        logic ok;
        channel_lock = 1'b1; adpll_mode = 2'd3;
        clear_mon();
        add_byte_exp(8'hA5);
        push_byte(8'hA5, 1'b1);
        wait_done(600, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_timeout busy=%0b required=0", tx_busy); end
        total++;
        if (got_q.size() != 8) begin
            bad++; $display("FAIL single_count got=%0d required=8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL single_bit%0d got=%0b required=%0b", i, got_q[i], exp_q[i]); end
            end
            for (int i = 1; i < 8; i++) begin
                total++;
                if (stb_t[i] - stb_t[i-1] != BC) begin bad++; $display("FAIL single_gap%0d got=%0d required=%0d", i, stb_t[i] - stb_t[i-1], BC); end
            end
            total++;
            if (fall_t - stb_t[0] != 8 * BC) begin bad++; $display("FAIL single_len got=%0d required=%0d", fall_t - stb_t[0], 8 * BC); end
        end
        total++;
        if (busy_cnt != 1 + 8 * BC) begin bad++; $display("FAIL single_busy got=%0d required=%0d", busy_cnt, 1 + 8 * BC); end
        total++;
        if (glitch != 0 || data_mod !== 1'b0) begin bad++; $display("FAIL single_hold glitch=%0d dm=%0b required=0,0", glitch, data_mod); end
    endtask

    task automatic test_wait_lock();
        logic ok;
        int hold_err;
        hold_err = 0;
        channel_lock = 1'b0; adpll_mode = 2'd3;
        clear_mon();
        add_byte_exp(8'h0F);
        push_byte(8'h0F, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_busy !== 1'b1 || data_mod !== 1'b0 || bit_stb !== 1'b0) hold_err++;
            if (i == 99) begin
                channel_lock = 1'b1; adpll_mode = 2'd3;
            end else if (i < 50) begin
                channel_lock = 1'b1; adpll_mode = 2'($urandom_range(0, 2));
            end else begin
                channel_lock = 1'b0; adpll_mode = 2'($urandom_range(0, 3));
            end
        end
        total++;
        if (hold_err != 0) begin bad++; $display("FAIL lock_wait_arm errs=%0d required=0", hold_err); end
        @(negedge clk);
        total++;
        if (bit_stb !== 1'b1 || data_mod !== 1'b1) begin
            bad++; $display("FAIL lock_first_bit stb=%0b dm=%0b required=1,1", bit_stb, data_mod);
        end
        wait_done(600, ok);
        total++;
        if (!ok || got_q.size() != 8) begin
            bad++; $display("FAIL lock_frame done=%0b bits=%0d required=1,8", ok, got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL lock_bit%0d got=%0b required=%0b", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_stream();
        logic ok;
        logic [7:0] b;
        channel_lock = 1'b1; adpll_mode = 2'd3;
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            add_byte_exp(b);
            push_byte(b, i == 5);
        end
        wait_done(3000, ok);
        total++;
        if (saw_full !== 1'b1) begin bad++; $display("FAIL stream_full_ready got=%0b required=1", saw_full); end
        total++;
        if (!ok || got_q.size() != 48) begin
            bad++; $display("FAIL stream_count done=%0b bits=%0d required=1,48", ok, got_q.size());
        end else begin
            for (int i = 0; i < 48; i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL stream_bit%0d got=%0b required=%0b", i, got_q[i], exp_q[i]); end
            end
            for (int i = 1; i < 48; i++) begin
                total++;
                if (stb_t[i] - stb_t[i-1] != BC) begin bad++; $display("FAIL stream_gap%0d got=%0d required=%0d", i, stb_t[i] - stb_t[i-1], BC); end
            end
        end
        total++;
        if (err_underrun !== 1'b0) begin bad++; $display("FAIL stream_underrun got=%0b required=0", err_underrun); end
        total++;
        if (busy_cnt != 1 + 48 * BC) begin bad++; $display("FAIL stream_busy got=%0d required=%0d", busy_cnt, 1 + 48 * BC); end
    endtask

    task automatic test_back_to_back();
        logic ok;
        logic [7:0] b0;
        logic [7:0] b1;
        int want;
        b0 = 8'($urandom_range(0, 255));
        b1 = 8'($urandom_range(0, 255));
        clear_mon();
        add_byte_exp(b0);
        add_byte_exp(b1);
        push_byte(b0, 1'b1);
        push_byte(b1, 1'b1);
        wait_done(600, ok);
        wait_done(600, ok);
        total++;
        if (!ok || got_q.size() != 16) begin
            bad++; $display("FAIL b2b_count done=%0b bits=%0d required=1,16", ok, got_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_bit%0d got=%0b required=%0b", i, got_q[i], exp_q[i]); end
            end
            for (int i = 1; i < 16; i++) begin
                want = (i == 8) ? BC + 2 : BC;
                total++;
                if (stb_t[i] - stb_t[i-1] != want) begin bad++; $display("FAIL b2b_gap%0d got=%0d required=%0d", i, stb_t[i] - stb_t[i-1], want); end
            end
        end
        total++;
        if (busy_cnt != 2 * (1 + 8 * BC)) begin bad++; $display("FAIL b2b_busy got=%0d required=%0d", busy_cnt, 2 * (1 + 8 * BC)); end
    endtask

    task automatic test_random_frames();
        logic ok;
        logic [7:0] b;
        int k;
        for (int f = 0; f < 3; f++) begin
            clear_mon();
            k = $urandom_range(1, 3);
            for (int i = 0; i < k; i++) begin
                b = 8'($urandom_range(0, 255));
                add_byte_exp(b);
                push_byte(b, i == k - 1);
            end
            wait_done(2000, ok);
            total++;
            if (!ok || got_q.size() != exp_q.size()) begin
                bad++; $display("FAIL rand%0d_count done=%0b bits=%0d required=1,%0d", f, ok, got_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    total++;
                    if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_bit%0d got=%0b required=%0b", f, i, got_q[i], exp_q[i]); end
                end
            end
            total++;
            if (busy_cnt != 1 + k * 8 * BC) begin bad++; $display("FAIL rand%0d_busy got=%0d required=%0d", f, busy_cnt, 1 + k * 8 * BC); end
        end
    endtask

    task automatic test_underrun();
        logic ok;
        clear_mon();
        add_byte_exp(8'h01);
        push_byte(8'h01, 1'b0);
        wait_done(600, ok);
        total++;
        if (!ok || err_underrun !== 1'b1) begin bad++; $display("FAIL underrun_flag done=%0b got=%0b required=1,1", ok, err_underrun); end
        total++;
        if (data_mod !== 1'b0 || tx_busy !== 1'b0 || err_lock !== 1'b0) begin
            bad++; $display("FAIL underrun_idle dm=%0b busy=%0b lock=%0b required=0,0,0", data_mod, tx_busy, err_lock);
        end
        total++;
        if (stb_t.size() != 8 || fall_t - stb_t[0] != 8 * BC) begin
            bad++; $display("FAIL underrun_len bits=%0d required=8 cycles=%0d", stb_t.size(), 8 * BC);
        end
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        total++;
        if (err_underrun !== 1'b0) begin bad++; $display("FAIL underrun_clear got=%0b required=0", err_underrun); end
    endtask

    task automatic test_lock_loss();
        logic ok;
        logic [7:0] b;
        clear_mon();
        channel_lock = 1'b1; adpll_mode = 2'd3;
        b = 8'($urandom_range(0, 255));
        add_byte_exp(b);
        push_byte(b, 1'b0);
        push_byte(8'($urandom_range(0, 255)), 1'b0);
        push_byte(8'($urandom_range(0, 255)), 1'b1);
        wait_bits(4, ok);
        repeat ($urandom_range(1, 20)) @(negedge clk);
        channel_lock = 1'b0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++;
        if (!ok || data_mod !== 1'b0 || tx_busy !== 1'b0 || bit_stb !== 1'b0) begin
            bad++; $display("FAIL lockloss_idle dm=%0b busy=%0b stb=%0b required=0,0,0", data_mod, tx_busy, bit_stb);
        end
        total++;
        if (err_lock !== 1'b1) begin bad++; $display("FAIL lockloss_flag got=%0b required=1", err_lock); end
        total++;
        if (got_q.size() != 4) begin
            bad++; $display("FAIL lockloss_bits got=%0d required=4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL lockloss_bit%0d got=%0b required=%0b", i, got_q[i], exp_q[i]); end
            end
        end
        channel_lock = 1'b1;
        repeat (40) @(negedge clk);
        total++;
        if (tx_busy !== 1'b0 || got_q.size() != 4) begin
            bad++; $display("FAIL lockloss_flushed busy=%0b bits=%0d required=0,4", tx_busy, got_q.size());
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        total++;
        if (err_lock !== 1'b0) begin bad++; $display("FAIL lockloss_clear got=%0b required=0", err_lock); end
    endtask

    task automatic test_en_drop();
        logic ok;
        clear_mon();
        push_byte(8'($urandom_range(0, 255)), 1'b0);
        push_byte(8'($urandom_range(0, 255)), 1'b1);
        wait_bits(2, ok);
        en = 1'b0;
        @(negedge clk);
        total++;
        if (!ok || tx_busy !== 1'b0 || data_mod !== 1'b0 || err_lock !== 1'b0 || tx_ready !== 1'b0) begin
            bad++; $display("FAIL endrop_idle busy=%0b dm=%0b lock=%0b rdy=%0b required=0,0,0,0",
                            tx_busy, data_mod, err_lock, tx_ready);
        end
        en = 1'b1;
        repeat (40) @(negedge clk);
        total++;
        if (tx_busy !== 1'b0 || got_q.size() > 3) begin
            bad++; $display("FAIL endrop_flushed busy=%0b bits=%0d required=0,<=3", tx_busy, got_q.size());
        end
    endtask

    task automatic test_async_reset();
        logic ok;
        int n0;
        clear_mon();
        push_byte(8'hFF, 1'b0);
        push_byte(8'hFF, 1'b1);
        wait_bits(3, ok);
        @(negedge clk);
        total++;
        if (!ok || data_mod !== 1'b1 || tx_busy !== 1'b1) begin
            bad++; $display("FAIL areset_pre dm=%0b busy=%0b required=1,1", data_mod, tx_busy);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({data_mod, bit_stb, tx_busy, err_lock, err_underrun} !== 5'b0) begin
            bad++; $display("FAIL areset_outputs got=%b required=00000",
                            {data_mod, bit_stb, tx_busy, err_lock, err_underrun});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (tx_ready !== 1'b1) begin bad++; $display("FAIL areset_ready got=%0b required=1", tx_ready); end
        n0 = got_q.size();
        repeat (40) @(negedge clk);
        total++;
        if (tx_busy !== 1'b0 || got_q.size() != n0) begin
            bad++; $display("FAIL areset_empty busy=%0b new_bits=%0d required=0,0", tx_busy, got_q.size() - n0);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_wait_lock();
        test_stream();
        test_back_to_back();
        test_random_frames();
        test_underrun();
        test_lock_loss();
        test_en_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
